adc_scan: RTL and testbench
===========================

// Module: adc_scan
// PURPOSE
//  Parametrised SPI master for the MCP300x/MCP320x ADC family (4/8 ch, 10/12 bit), all logic on sclk.
//  Runs single-shot conversions or a continuous masked round-robin scan.
//  Stores the latest result of every channel in a flat register bank and flags each new result.
//  Sits between the ADC pins and the sensor-acquisition logic.
// PARAMETERS
//  NCH    8   number of channels, 1..8; channel address is always 3 bits (D2..D0)
//  DW     12  conversion width in bits (10 for MCP300x, 12 for MCP320x)
//  GAP    2   sclk negedges cs_n is held high between frames, >=1
// PORTS
//  sclk       in   1       serial clock; control on negedge, sdi capture on posedge
//  rst_n      in   1       asynchronous reset, active-low
//  mode       in   1       0: single-shot, 1: continuous scan
//  start      in   1       single-shot request, level-sampled on negedge in IDLE
//  ch_sel     in   3       single-shot channel
//  diff       in   1       1: pseudo-differential (SGL/DIFF bit = 0), 0: single-ended
//  ch_mask    in   NCH     scan enable per channel; bit i = channel i
//  sdi        in   1       ADC DOUT
//  sdo        out  1       ADC DIN
//  cs_n       out  1       ADC chip select, active-low
//  busy       out  1       high while not in IDLE
//  vld        out  1       one-sclk pulse: new result written
//  vld_ch     out  3       channel of the result flagged by vld
//  scan_done  out  1       one-sclk pulse with vld of the last enabled channel in a scan pass
//  vec        out  NCH*DW  result bank; channel i at vec[i*DW +: DW]
// BEHAVIOUR
//  Reset: cs_n=1, sdo=0, busy=0, vld=0, scan_done=0, vld_ch=0, vec=0, state IDLE.
//   Reset is effective immediately and also mid-frame.
//  FSM (negedge): IDLE -> CONV -> GAP -> IDLE, or GAP -> CONV when a scan is still active.
//  Frame negedge count k: k=0 is the negedge that enters CONV.
//   k=0: cs_n<=0; sdo<=1 (start bit); latch the frame's channel and SGL bit.
//   k=1..4: sdo <= SGL, D2, D1, D0. k>=5: sdo<=0.
//   Posedges following negedges k=7..6+DW shift sdi into the capture register, MSB first.
//   Posedges outside that window leave the capture register unchanged.
//   k=7+DW: cs_n<=1; vec[ch] <= capture; vld<=1; vld_ch<=ch; go to GAP.
//   The ADC null bit (negedge 6) is not captured. Frame length: 8+DW negedges with cs_n low.
//  GAP: cs_n stays high for GAP negedges including k=7+DW, then re-evaluate.
//  Input sampling: mode, ch_sel, diff and ch_mask are sampled only at k=0.
//   Changes mid-frame affect the next frame only.
//  Single-shot: in IDLE with mode=0 and start=1, the next negedge is k=0 for ch_sel.
//   After GAP, return to IDLE. A held start retriggers.
//   start during CONV or GAP is ignored.
//  Scan: in IDLE with mode=1 and ch_mask!=0, enter CONV on the lowest enabled channel.
//   After each GAP, take the next enabled channel above the current one, wrapping to the lowest.
//   Evaluate mode and ch_mask at that point: mode=0 or mask=0 -> IDLE.
//   Wrap event: scan_done pulses together with vld of the highest enabled channel.
//  Channel numbers >= NCH (ch_sel) are sent on D2..D0, but the result is discarded.
//   vld still pulses with vld_ch=ch_sel.
//  vld and scan_done are high for exactly one negedge-to-negedge period.
//  Registers of unconverted channels hold their values. Results are zero-extended to nothing; exactly DW bits are stored.
// TESTING
//  1 Reset mid-frame (k=10) -> cs_n=1 and vec=0 immediately; restart frame is clean.
//  2 Single-shot, mode=0, ch_sel=5, diff=0, ADC model returns 12'hA5C
//    -> sdo bits 1,1,1,0,1; vec[5*12+:12]=12'hA5C; vld 1 cycle, vld_ch=5; 20 negedges with cs_n low.
//  3 Scan, ch_mask=8'b1000_0101, model returns 100*ch+1
//    -> order 0,2,7,0...; vec ch0=1, ch2=201, ch7=701; scan_done only with ch7; GAP=2 high negedges between frames.
//  4 Clear mode mid-frame of ch2 -> frame completes, result stored, then IDLE with busy=0.
//    Zero ch_mask with mode=1 -> stays IDLE.
//  5 DW=10, NCH=4, diff=1, ch_sel=3 -> sdo 1,0,0,1,1; 18 cs_n-low negedges; 10-bit value stored.
//  6 start pulsed during GAP -> ignored; start held high -> back-to-back frames separated by GAP.

Source files
------------

// File: rtl/adc_scan.sv
// adc_scan: SPI master for the MCP300x/MCP320x ADC family. It runs single-shot or masked
// round-robin scan conversions and keeps the latest result of each channel in a flat bank.
//   sclk      in  serial clock; control logic on negedge, sdi captured on posedge
//   rst_n     in  asynchronous reset, active-low
//   mode      in  0: single-shot, 1: continuous scan
//   start     in  single-shot request, level-sampled in IDLE
//   ch_sel    in  single-shot channel
//   diff      in  1: pseudo-differential, 0: single-ended
//   ch_mask   in  scan enable per channel
//   sdi       in  ADC DOUT
//   sdo       out ADC DIN
//   cs_n      out ADC chip select, active-low
//   busy      out high while not idle
//   vld       out one-period pulse when a result is written
//   vld_ch    out channel of the result flagged by vld
//   scan_done out pulses with vld of the last enabled channel in a scan pass
//   vec       out result bank, channel i at vec[i*DW +: DW]
module adc_scan #(
    parameter int NCH = 8,
    parameter int DW  = 12,
    parameter int GAP = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start,
    input  logic [2:0]        ch_sel,
    input  logic              diff,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              sdi,
    output logic              sdo,
    output logic              cs_n,
    output logic              busy,
    output logic              vld,
    output logic [2:0]        vld_ch,
    output logic              scan_done,
    output logic [NCH*DW-1:0] vec
);
    localparam int CW = $clog2(DW + GAP + 9);
    localparam logic [CW-1:0] K_CAP0 = CW'(7);
    localparam logic [CW-1:0] K_CAP1 = CW'(6 + DW);
    localparam logic [CW-1:0] K_END  = CW'(7 + DW);
    localparam logic [CW-1:0] K_EVAL = CW'(7 + DW + GAP);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, kn;
    logic [2:0]          ch_q, ch_d, vld_ch_q, vld_ch_d, new_ch;
    logic                sgl_q, sgl_d, scan_q, scan_d;
    logic [NCH-1:0]      mask_q, mask_d;
    logic                cs_n_q, cs_n_d, sdo_q, sdo_d;
    logic                vld_q, vld_d, done_q, done_d;
    logic [NCH*DW-1:0]   vec_q, vec_d;
    logic [DW-1:0]       cap_q, cap_d;
    logic                go, cont, launch;

    function automatic logic [2:0] lowest(input logic [NCH-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Smallest enabled channel above cur, wrapping to the lowest one.
    function automatic logic [2:0] next_ch(input logic [NCH-1:0] m, input logic [2:0] cur);
        logic [2:0] r;
        r = lowest(m);
        for (int i = NCH - 1; i >= 0; i--) if (m[i] && 3'(i) > cur) r = 3'(i);
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        sgl_d    = sgl_q;
        scan_d   = scan_q;
        mask_d   = mask_q;
        cs_n_d   = cs_n_q;
        sdo_d    = sdo_q;
        vld_d    = 1'b0;
        vld_ch_d = vld_ch_q;
        done_d   = 1'b0;
        vec_d    = vec_q;
        launch   = 1'b0;
        kn       = cnt_q + CW'(1);
        go       = mode ? |ch_mask : start;
        // A scan only continues from the end of a gap that followed a scan frame.
        cont     = (state_q == S_GAP) && scan_q && mode && |ch_mask;
        new_ch   = cont ? next_ch(ch_mask, ch_q) : (mode ? lowest(ch_mask) : ch_sel);
        unique case (state_q)
            S_IDLE: launch = go;
            S_CONV: begin
                cnt_d = kn;
                sdo_d = (kn == CW'(1)) ? sgl_q :
                        (kn == CW'(2)) ? ch_q[2] :
                        (kn == CW'(3)) ? ch_q[1] :
                        (kn == CW'(4)) ? ch_q[0] : 1'b0;
                if (kn == K_END) begin
                    state_d  = S_GAP;
                    cs_n_d   = 1'b1;
                    vld_d    = 1'b1;
                    vld_ch_d = ch_q;
                    // The pass ends when no enabled channel lies above this one.
                    done_d   = scan_q && (next_ch(mask_q, ch_q) <= ch_q);
                    // Channels beyond NCH match no slot, so their result is dropped.
                    for (int i = 0; i < NCH; i++) if (ch_q == 3'(i)) vec_d[i*DW +: DW] = cap_q;
                end
            end
            S_GAP: begin
                cnt_d = kn;
                if (kn == K_EVAL) begin
                    state_d = S_IDLE;
                    launch  = go;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            state_d = S_CONV;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            sdo_d   = 1'b1;
            ch_d    = new_ch;
            sgl_d   = ~diff;
            scan_d  = mode;
            mask_d  = ch_mask;
        end
    end

    // The null bit (after negedge 6) is skipped; DW bits follow MSB first.
    always_comb begin
        cap_d = (state_q == S_CONV && cnt_q >= K_CAP0 && cnt_q <= K_CAP1) ?
                {cap_q[DW-2:0], sdi} : cap_q;
    end

    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            sgl_q    <= 1'b0;
            scan_q   <= 1'b0;
            mask_q   <= '0;
            cs_n_q   <= 1'b1;
            sdo_q    <= 1'b0;
            vld_q    <= 1'b0;
            vld_ch_q <= '0;
            done_q   <= 1'b0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            sgl_q    <= sgl_d;
            scan_q   <= scan_d;
            mask_q   <= mask_d;
            cs_n_q   <= cs_n_d;
            sdo_q    <= sdo_d;
            vld_q    <= vld_d;
            vld_ch_q <= vld_ch_d;
            done_q   <= done_d;
            vec_q    <= vec_d;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) cap_q <= '0;
        else        cap_q <= cap_d;
    end

    assign sdo       = sdo_q;
    assign cs_n      = cs_n_q;
    assign busy      = (state_q != S_IDLE);
    assign vld       = vld_q;
    assign vld_ch    = vld_ch_q;
    assign scan_done = done_q;
    assign vec       = vec_q;
endmodule

// File: tb/tb_adc_scan.sv
// tb_adc_scan: directed bench for adc_scan with a behavioural MCP3x0x model per instance.
module tb_adc_scan;
    logic        sclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode = 1'b0, start = 1'b0, diff = 1'b0;
    logic [2:0]  ch_sel = '0;
    logic [7:0]  ch_mask = '0;
    logic        sdi_a = 1'b0, sdo_a, cs_n_a, busy_a, vld_a, done_a;
    logic [2:0]  vld_ch_a;
    logic [95:0] vec_a;
    logic        mode_b = 1'b0, start_b = 1'b0;
    logic [3:0]  ch_mask_b = '0;
    logic        sdi_b = 1'b0, sdo_b, cs_n_b, busy_b, vld_b, done_b;
    logic [2:0]  vld_ch_b;
    logic [39:0] vec_b;

    int checks = 0, failures = 0;

    always #5 sclk = ~sclk;

    adc_scan #(.NCH(8), .DW(12), .GAP(2)) dut_a (
        .sclk(sclk), .rst_n(rst_n), .mode(mode), .start(start), .ch_sel(ch_sel),
        .diff(diff), .ch_mask(ch_mask), .sdi(sdi_a), .sdo(sdo_a), .cs_n(cs_n_a),
        .busy(busy_a), .vld(vld_a), .vld_ch(vld_ch_a), .scan_done(done_a), .vec(vec_a));

    adc_scan #(.NCH(4), .DW(10), .GAP(2)) dut_b (
        .sclk(sclk), .rst_n(rst_n), .mode(mode_b), .start(start_b), .ch_sel(ch_sel),
        .diff(diff), .ch_mask(ch_mask_b), .sdi(sdi_b), .sdo(sdo_b), .cs_n(cs_n_b),
        .busy(busy_b), .vld(vld_b), .vld_ch(vld_ch_b), .scan_done(done_b), .vec(vec_b));

    // ADC models: k counts negedges since cs_n fell; the command is read on posedges k=0..4,
    // the conversion is driven after negedges 7..6+DW, MSB first.
    logic [11:0] aval [8];
    logic [9:0]  bval [8];
    int ka = 100, hia = 0, lena = 0, gapa = 0;
    int kb = 100, hib = 0, lenb = 0, gapb = 0;
    logic pcs_a = 1'b1, pcs_b = 1'b1;
    logic [4:0] cmda = '0, cmdb = '0;
    logic [11:0] sha = '0;
    logic [9:0]  shb = '0;

    always @(negedge sclk) begin
        #1;
        if (!cs_n_a) begin
            if (pcs_a) begin ka = 0; cmda = '0; gapa = hia; hia = 0; end
            else ka++;
            if (ka == 7) sha = aval[cmda[2:0]];
            else sha = sha << 1;
            sdi_a = (ka >= 7 && ka <= 18) ? sha[11] : 1'b0;
        end else begin
            if (!pcs_a) lena = ka + 2;
            hia++;
            sdi_a = 1'b0;
        end
        pcs_a = cs_n_a;
    end

    always @(negedge sclk) begin
        #1;
        if (!cs_n_b) begin
            if (pcs_b) begin kb = 0; cmdb = '0; gapb = hib; hib = 0; end
            else kb++;
            if (kb == 7) shb = bval[cmdb[2:0]];
            else shb = shb << 1;
            sdi_b = (kb >= 7 && kb <= 16) ? shb[9] : 1'b0;
        end else begin
            if (!pcs_b) lenb = kb + 2;
            hib++;
            sdi_b = 1'b0;
        end
        pcs_b = cs_n_b;
    end

    always @(posedge sclk) if (!cs_n_a && ka < 5) cmda = {cmda[3:0], sdo_a};
    always @(posedge sclk) if (!cs_n_b && kb < 5) cmdb = {cmdb[3:0], sdo_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task tick();
        @(negedge sclk);
        #2;
    endtask

    task automatic wait_vld(input bit b, input string name);
        int n = 0;
        while (!(b ? vld_b : vld_a) && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s: no vld within 200 cycles", name);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic        df;
        logic [11:0] val;
        logic [4:0]  cmd;
    } vec_t;
    vec_t tv[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        logic [39:0] vb;
        tv[0] = '{3'd5, 1'b0, 12'hA5C, 5'b11101};
        tv[1] = '{3'd0, 1'b0, 12'h001, 5'b11000};
        tv[2] = '{3'd7, 1'b1, 12'hFFF, 5'b10111};
        tv[3] = '{3'd2, 1'b1, 12'h800, 5'b10010};
        tv[4] = '{3'd3, 1'b0, 12'h5A3, 5'b11011};
        for (int i = 0; i < 8; i++) begin aval[i] = '0; bval[i] = '0; end

        #1 rst_n = 1'b0;
        #2;
        chk("rst_cs_n", 32'(cs_n_a), 1);
        chk("rst_sdo", 32'(sdo_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_vld", 32'(vld_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_vld_ch", 32'(vld_ch_a), 0);
        chk("rst_vec", 32'(vec_a != '0), 0);
        tick();
        tick();
        #1 rst_n = 1'b1;
        tick();

        // Single-shot table, including the 12'hA5C channel-5 case.
        for (int i = 0; i < 5; i++) begin
            ch_sel = tv[i].ch;
            diff = tv[i].df;
            aval[tv[i].ch] = tv[i].val;
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_vld(0, $sformatf("tv%0d_vld", i));
            chk($sformatf("tv%0d_vld_ch", i), 32'(vld_ch_a), 32'(tv[i].ch));
            chk($sformatf("tv%0d_vec", i), 32'(vec_a[int'(tv[i].ch)*12 +: 12]), 32'(tv[i].val));
            chk($sformatf("tv%0d_cmd", i), 32'(cmda), 32'(tv[i].cmd));
            chk($sformatf("tv%0d_done", i), 32'(done_a), 0);
            chk($sformatf("tv%0d_len", i), 32'(lena), 20);
            tick();
            chk($sformatf("tv%0d_vld_pulse", i), 32'(vld_a), 0);
            chk($sformatf("tv%0d_busy_gap", i), 32'(busy_a), 1);
            tick();
            chk($sformatf("tv%0d_busy_idle", i), 32'(busy_a), 0);
        end
        chk("hold_ch5", 32'(vec_a[60 +: 12]), 32'h0A5C);
        chk("hold_ch1", 32'(vec_a[12 +: 12]), 0);

        // Reset in the middle of a frame.
        ch_sel = 3'd1;
        diff = 1'b0;
        aval[1] = 12'h3C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lows = 0;
        while (!(ka == 10 && !cs_n_a) && lows < 40) begin tick(); lows++; end
        chk("mid_k10_reached", 32'(ka), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n_a), 1);
        chk("mid_rst_vec", 32'(vec_a != '0), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        #1 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vld(0, "restart_vld");
        chk("restart_vec", 32'(vec_a[12 +: 12]), 32'h3C3);
        chk("restart_cmd", 32'(cmda), 32'b11001);
        chk("restart_len", 32'(lena), 20);
        chk("restart_ch5_cleared", 32'(vec_a[60 +: 12]), 0);
        tick();
        tick();

        // Scan over channels 0, 2 and 7.
        aval[0] = 12'd1;
        aval[2] = 12'd201;
        aval[7] = 12'd701;
        ch_mask = 8'b1000_0101;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int ec;
            ec = (i == 1) ? 2 : (i == 2) ? 7 : 0;
            wait_vld(0, $sformatf("scan%0d_vld", i));
            chk($sformatf("scan%0d_ch", i), 32'(vld_ch_a), 32'(ec));
            chk($sformatf("scan%0d_done", i), 32'(done_a), 32'(i == 2));
            chk($sformatf("scan%0d_vec", i), 32'(vec_a[ec*12 +: 12]), 32'(100 * ec + 1));
            if (i > 0) chk($sformatf("scan%0d_gap", i), 32'(gapa), 2);
            tick();
            chk($sformatf("scan%0d_pulse", i), 32'({vld_a, done_a}), 0);
        end
        lows = 0;
        while (cs_n_a && lows < 10) begin tick(); lows++; end
        chk("scan_ch2_started", 32'(cs_n_a), 0);
        tick();
        tick();
        mode = 1'b0;
        wait_vld(0, "stop_vld");
        chk("stop_ch", 32'(vld_ch_a), 2);
        chk("stop_done", 32'(done_a), 0);
        chk("stop_vec", 32'(vec_a[24 +: 12]), 201);
        tick();
        chk("stop_busy_gap", 32'(busy_a), 1);
        tick();
        chk("stop_busy_idle", 32'(busy_a), 0);
        lows = 0;
        for (int i = 0; i < 30; i++) begin tick(); lows += int'(!cs_n_a); end
        chk("stop_stays_idle", 32'(lows), 0);
        ch_mask = '0;
        mode = 1'b1;
        lows = 0;
        for (int i = 0; i < 10; i++) begin tick(); lows += int'(busy_a); end
        chk("zero_mask_idle", 32'(lows), 0);
        mode = 1'b0;

        // Start pulsed during GAP is ignored; held start repeats with GAP spacing.
        ch_sel = 3'd4;
        aval[4] = 12'h444;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vld(0, "gap_vld");
        start = 1'b1;
        tick();
        start = 1'b0;
        lows = 0;
        for (int i = 0; i < 25; i++) begin tick(); lows += int'(!cs_n_a) + int'(busy_a); end
        chk("gap_start_ignored", 32'(lows), 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_vld(0, $sformatf("held%0d_vld", i));
            chk($sformatf("held%0d_ch", i), 32'(vld_ch_a), 4);
            if (i > 0) chk($sformatf("held%0d_gap", i), 32'(gapa), 2);
            if (i < 2) tick();
        end
        start = 1'b0;
        tick();
        tick();
        chk("held_release_idle", 32'(busy_a), 0);

        // Narrow instance: 10-bit, 4 channels, pseudo-differential, out-of-range channel.
        ch_sel = 3'd3;
        diff = 1'b1;
        bval[3] = 10'h2B7;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_vld(1, "b_vld");
        chk("b_ch", 32'(vld_ch_b), 3);
        chk("b_vec", 32'(vec_b[30 +: 10]), 32'h2B7);
        chk("b_cmd", 32'(cmdb), 32'b10011);
        chk("b_len", 32'(lenb), 18);
        chk("b_done", 32'(done_b), 0);
        tick();
        tick();
        chk("b_idle", 32'(busy_b), 0);
        vb = vec_b;
        ch_sel = 3'd6;
        diff = 1'b0;
        bval[6] = 10'h155;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_vld(1, "b6_vld");
        chk("b6_ch", 32'(vld_ch_b), 6);
        chk("b6_cmd", 32'(cmdb), 32'b11110);
        chk("b6_discard", 32'(vec_b != vb), 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
